rc4_prga_encrypt: RTL and testbench

- RC4 keystream generator (PRGA) plus XOR stage.
- Encrypts a MSG_LEN-byte plaintext from an on-chip ROM into a ciphertext RAM.
- Runs after the key-scheduling stage has initialised the 256x8 S memory. It is the encode-side counterpart of the decrypt path.
- Sits beside the KSA controller in the top level and shares the S RAM through a mux owned by the top-level controller.

---
 rtl/rc4_prga_encrypt.sv | 135 +++++++++++++
 tb/tb_rc4_prga_encrypt.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_encrypt.sv
// RC4 keystream generator (PRGA) with XOR stage: encrypts MSG_LEN plaintext
// bytes from a ROM into a ciphertext RAM using an already-scheduled S RAM.
module rc4_prga_encrypt #(
   parameter int MSG_LEN = 32,
   parameter int MSG_AW  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [7:0]        s_addr,
   output logic [7:0]        s_wrdata,
   output logic              s_wren,
   input  logic [7:0]        s_rddata,
   output logic [MSG_AW-1:0] pt_addr,
   input  logic [7:0]        pt_rddata,
   output logic [MSG_AW-1:0] ct_addr,
   output logic [7:0]        ct_wrdata,
   output logic              ct_wren
);

   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, RD_F, WAIT_F, WR_CT, DONE
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        i_q, i_d;
   logic [7:0]        j_q, j_d;
   logic [MSG_AW-1:0] k_q, k_d;
   logic [7:0]        si_q, si_d;
   logic [7:0]        sj_q, sj_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

   // Addresses are driven combinationally in the issuing state; the two-cycle
   // memory latency is absorbed by the WAIT states, so read data lands exactly
   // in the state that consumes it.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      si_d      = si_q;
      sj_d      = sj_q;
      busy      = (state_q != IDLE) && (state_q != DONE);
      done      = 1'b0;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      pt_addr   = '0;
      ct_addr   = '0;
      ct_wrdata = '0;
      ct_wren   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = RD_I;
            end
         end
         RD_I: begin
            i_d     = i_q + 8'd1;
            s_addr  = i_q + 8'd1;
            state_d = WAIT_I;
         end
         WAIT_I: state_d = RD_J;
         RD_J: begin
            si_d    = s_rddata;
            j_d     = j_q + s_rddata;
            s_addr  = j_q + s_rddata;
            state_d = WAIT_J;
         end
         WAIT_J: state_d = WR_I;
         WR_I: begin
            sj_d     = s_rddata;
            s_addr   = i_q;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            state_d  = WR_J;
         end
         // When i == j this rewrites the same location with the original S[i].
         WR_J: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            state_d  = RD_F;
         end
         RD_F: begin
            s_addr  = si_q + sj_q;
            pt_addr = k_q;
            state_d = WAIT_F;
         end
         WAIT_F: state_d = WR_CT;
         WR_CT: begin
            ct_addr   = k_q;
            ct_wrdata = s_rddata ^ pt_rddata;
            ct_wren   = 1'b1;
            if (k_q == K_LAST) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = RD_I;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rc4_prga_encrypt.sv
// Self-checking bench for rc4_prga_encrypt: memories with 2-cycle read latency
// around the DUT and an array-based RC4 reference model.
module tb_rc4_prga_encrypt;

   localparam int MSG_LEN = 32;
   localparam int MSG_AW  = 5;
   localparam int RUN_CYC = 9 * MSG_LEN + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, s_wren, ct_wren;
   logic [7:0]        s_addr, s_wrdata, s_rddata, pt_rddata, ct_wrdata;
   logic [MSG_AW-1:0] pt_addr, ct_addr;

   rc4_prga_encrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
      .pt_addr(pt_addr), .pt_rddata(pt_rddata),
      .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
   );

   always #5 clk = ~clk;

   logic [7:0] smem [256];
   logic [7:0] snap [256];
   logic [7:0] s_init [256];
   logic [7:0] pmem [MSG_LEN];
   logic [7:0] cmem [MSG_LEN];
   logic [7:0] s_p1, p_p1;
   logic       load_req = 1'b0;
   int         snap_at = 2;

   always @(posedge clk) begin
      s_p1      <= smem[s_addr];
      s_rddata  <= s_p1;
      p_p1      <= pmem[pt_addr];
      pt_rddata <= p_p1;
      if (load_req) begin
         for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
      end else if (s_wren) begin
         smem[s_addr] <= s_wrdata;
      end
      if (ct_wren) cmem[ct_addr] <= ct_wrdata;
      if (ct_wren && int'(ct_addr) == snap_at) begin
         for (int a = 0; a < 256; a++) snap[a] <= smem[a];
      end
   end

   // Reference model state: S permutation carried across runs like the RAM.
   logic [7:0] ms [256];
   logic [7:0] exp_ct [MSG_LEN];
   logic [7:0] tmp [MSG_LEN];
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit         from_s;
      int         addr;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_run();
      int i = 0;
      int j = 0;
      logic [7:0] t;
      for (int k = 0; k < MSG_LEN; k++) begin
         i = (i + 1) % 256;
         j = (j + int'(ms[i])) % 256;
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         exp_ct[k] = ms[(int'(ms[i]) + int'(ms[j])) % 256] ^ pmem[k];
      end
   endtask

   task automatic load_s();
      for (int a = 0; a < 256; a++) ms[a] = s_init[a];
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic identity_s();
      for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
      load_s();
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of DONE.
   task automatic do_run(input string name, input bit hold);
      int  n = 0, nwr = 0, nsw = 0, done_at = -1;
      bit  order_ok = 1'b1, excl_ok = 1'b1;
      model_run();
      chk({name, " busy_idle"}, int'(busy), 0);
      start = 1'b1;
      while (n < RUN_CYC + 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            if (!hold) start = 1'b0;
            chk({name, " busy_rise"}, int'(busy), 1);
         end
         if (s_wren && ct_wren) excl_ok = 1'b0;
         if (s_wren) nsw++;
         if (ct_wren) begin
            if (int'(ct_addr) != nwr) order_ok = 1'b0;
            nwr++;
         end
         if (done) begin
            done_at = n;
            break;
         end
      end
      if (!hold) start = 1'b0;
      chk({name, " done_cycle"}, done_at, RUN_CYC);
      chk({name, " busy_at_done"}, int'(busy), 0);
      chk({name, " ct_writes"}, nwr, MSG_LEN);
      chk({name, " s_writes"}, nsw, 2 * MSG_LEN);
      chk({name, " ct_order"}, int'(order_ok), 1);
      chk({name, " wren_exclusive"}, int'(excl_ok), 1);
      for (int k = 0; k < MSG_LEN; k++)
         chk($sformatf("%s ct[%0d]", name, k), int'(cmem[k]), int'(exp_ct[k]));
   endtask

   task automatic check_outputs_zero(input string name);
      chk({name, " busy"}, int'(busy), 0);
      chk({name, " done"}, int'(done), 0);
      chk({name, " wrens"}, int'({s_wren, ct_wren}), 0);
      chk({name, " s_bus"}, int'({s_addr, s_wrdata}), 0);
      chk({name, " msg_bus"}, int'({pt_addr, ct_addr, ct_wrdata}), 0);
   endtask

   initial begin
      int n, nwr, nact;

      vecs[0] = '{1'b0, 0, 8'h02};
      vecs[1] = '{1'b0, 1, 8'h05};
      vecs[2] = '{1'b0, 2, 8'h07};
      vecs[3] = '{1'b1, 2, 8'h03};
      vecs[4] = '{1'b1, 3, 8'h05};
      vecs[5] = '{1'b1, 5, 8'h02};

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("idle");

      // Identity S, zero plaintext: known keystream and S after byte 2.
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'h00;
      identity_s();
      snap_at = 2;
      do_run("ident", 1'b0);
      foreach (vecs[v]) begin
         if (vecs[v].from_s)
            chk($sformatf("ident S[%0d]", vecs[v].addr), int'(snap[vecs[v].addr]), int'(vecs[v].exp));
         else
            chk($sformatf("ident vec ct[%0d]", vecs[v].addr), int'(cmem[vecs[v].addr]), int'(vecs[v].exp));
      end
      @(negedge clk);

      // Round trip: encrypt then decrypt with the same initial S.
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'(8'h41 + k);
      identity_s();
      do_run("rt_enc", 1'b0);
      @(negedge clk);
      for (int k = 0; k < MSG_LEN; k++) tmp[k] = cmem[k];
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = tmp[k];
      identity_s();
      do_run("rt_dec", 1'b0);
      for (int k = 0; k < MSG_LEN; k++)
         chk($sformatf("rt plain[%0d]", k), int'(cmem[k]), 8'h41 + k);
      @(negedge clk);

      // Back-to-back runs with start held: S carries over between runs.
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'($urandom);
      identity_s();
      do_run("b2b_1", 1'b1);
      @(negedge clk);
      chk("b2b gap wrens", int'({s_wren, ct_wren}), 0);
      chk("b2b gap busy", int'(busy), 0);
      do_run("b2b_2", 1'b1);
      start = 1'b0;
      @(negedge clk);

      // Reset during WR_I of byte 5 aborts the run with no further writes.
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'h00;
      identity_s();
      model_run();
      start = 1'b1;
      n = 0; nwr = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (s_wren && nwr == 5) break;
         if (ct_wren) nwr++;
      end
      chk("abort reached byte5 WR_I", n, 9 * 5 + 5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_outputs_zero("abort");
      nact = 0;
      repeat (40) begin
         @(negedge clk);
         if (s_wren || ct_wren || busy) nact++;
      end
      chk("abort quiet", nact, 0);
      for (int k = 0; k < 5; k++)
         chk($sformatf("abort partial ct[%0d]", k), int'(cmem[k]), int'(exp_ct[k]));
      identity_s();
      do_run("after_abort", 1'b0);
      chk("after_abort ct0", int'(cmem[0]), 8'h02);
      @(negedge clk);

      // S[1]=0xFF: the byte-0 swap leaves S[1] at 0xFF.
      for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'($urandom);
      for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
      s_init[1] = 8'hFF;
      load_s();
      snap_at = 0;
      do_run("swap", 1'b0);
      chk("swap S[1]", int'(snap[1]), 8'hFF);
      chk("swap ct0", int'(cmem[0]), int'(8'hFE ^ pmem[0]));
      @(negedge clk);

      // Random permutations and plaintexts against the reference model.
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
         for (int a = 255; a > 0; a--) begin
            int b;
            logic [7:0] t;
            b = int'($urandom_range(a, 0));
            t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
         end
         for (int k = 0; k < MSG_LEN; k++) pmem[k] = 8'($urandom);
         load_s();
         do_run($sformatf("rand%0d", r), 1'b0);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
